// File: rtl/dmem_responder_if.sv
// Data-memory bus bundle: CPU load/store port plus the side preload port.
// master drives requests (CPU / boot logic); slave is the memory responder.
//   dmem_w_en, dmem_addr, dmem_wdata : CPU store strobe, word address, data
//   dmem_rdata, dmem_ready           : combinational read data, array ready
//   pl_valid, pl_addr, pl_data       : preload request
//   pl_ready                         : preload accepted this cycle
interface dmem_responder_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);

    logic              dmem_w_en;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic [WIDTH-1:0]  dmem_rdata;
    logic              dmem_ready;

    logic              pl_valid;
    logic [ADDR_W-1:0] pl_addr;
    logic [WIDTH-1:0]  pl_data;
    logic              pl_ready;

    modport master (
        output dmem_w_en,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready,
        output pl_valid,
        output pl_addr,
        output pl_data,
        input  pl_ready
    );

    modport slave (
        input  dmem_w_en,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready,
        input  pl_valid,
        input  pl_addr,
        input  pl_data,
        output pl_ready
    );

endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH x WIDTH array, combinational read, clocked
// write, zeroed by a clear sweep after every reset, with a side preload port.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : dmem_responder_if.slave (CPU port + preload handshake)
//   wr_count   : saturating count of committed CPU stores
module dmem_responder #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready;
    logic              cpu_we;
    logic              pl_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    assign ready = (state == S_READY);

    // CPU store always wins the single write port; the preload requester
    // must hold its request until it sees pl_ready.
    assign cpu_we = ready & bus.dmem_w_en;
    assign pl_we  = ready & bus.pl_valid & ~bus.dmem_w_en;

    assign bus.dmem_ready = ready;
    assign bus.pl_ready   = pl_we;
    assign bus.dmem_rdata = ready ? mem[bus.dmem_addr] : '0;

    // Write-port mux: the clear sweep owns the port while not ready.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (!ready) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
            end else if (cpu_we) begin
                mem_we    = 1'b1;
                mem_waddr = bus.dmem_addr;
                mem_wdata = bus.dmem_wdata;
            end else if (pl_we) begin
                mem_we    = 1'b1;
                mem_waddr = bus.pl_addr;
                mem_wdata = bus.pl_data;
            end
        end
    end

    // Array has no reset of its own; contents are zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) begin
                        state <= S_READY;
                    end
                end
                default: begin
                    state <= S_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (cpu_we && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: clear sweep timing, read/write
// ordering, preload arbitration, reset mid-sweep and counter saturation.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_responder_if #(.WIDTH(32), .ADDR_W(6)) a ();
    dmem_responder_if #(.WIDTH(32), .ADDR_W(6)) b ();

    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    dmem_responder #(.WIDTH(32), .DEPTH(64), .ADDR_W(6), .CNT_W(16)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (a),
        .wr_count (cnt_a)
    );

    dmem_responder #(.WIDTH(32), .DEPTH(64), .ADDR_W(6), .CNT_W(4)) u_sat (
        .clk      (clk),
        .reset    (reset),
        .bus      (b),
        .wr_count (cnt_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where dmem_ready is first seen high.
    task automatic wait_ready(output int n, output logic nz);
        n  = 0;
        nz = 1'b0;
        forever begin
            @(negedge clk);
            if (a.dmem_ready === 1'b1) break;
            if (a.dmem_rdata !== 32'h0) nz = 1'b1;
            n++;
            if (n > 200) break;
            a.dmem_addr = 6'(n * 7);
            @(posedge clk);
            #1;
        end
    endtask

    int   n;
    logic nz;

    initial begin
        reset = 1'b1;
        a.dmem_w_en = 1'b0; a.dmem_addr = '0; a.dmem_wdata = '0;
        a.pl_valid = 1'b0;  a.pl_addr = '0;   a.pl_data = '0;
        b.dmem_w_en = 1'b0; b.dmem_addr = '0; b.dmem_wdata = '0;
        b.pl_valid = 1'b0;  b.pl_addr = '0;   b.pl_data = '0;

        // Reset values, with a preload request pending.
        cyc();
        a.pl_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(a.dmem_ready), 32'd0);
        chk("rst_plready", 32'(a.pl_ready), 32'd0);
        chk("rst_rdata", a.dmem_rdata, 32'h0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        cyc();
        reset = 1'b0;
        a.pl_valid = 1'b0;

        // Clear sweep length and zero read data throughout.
        wait_ready(n, nz);
        chk("clear_len", 32'(n), 32'd64);
        chk("clear_rdata", 32'(nz), 32'd0);
        a.dmem_addr = 6'd0;  #1; chk("rd0", a.dmem_rdata, 32'h0);
        a.dmem_addr = 6'd31; #1; chk("rd31", a.dmem_rdata, 32'h0);
        a.dmem_addr = 6'd63; #1; chk("rd63", a.dmem_rdata, 32'h0);
        cyc();

        // Store and read same address: old value first, new value next.
        a.dmem_w_en = 1'b1; a.dmem_addr = 6'd5; a.dmem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st5_same", a.dmem_rdata, 32'h0);
        cyc();
        a.dmem_w_en = 1'b0;
        @(negedge clk);
        chk("st5_next", a.dmem_rdata, 32'hDEADBEEF);
        chk("st5_count", 32'(cnt_a), 32'd1);
        cyc();

        // Preload collides with a CPU store, then goes through.
        a.pl_valid = 1'b1; a.pl_addr = 6'd10; a.pl_data = 32'h12345678;
        a.dmem_w_en = 1'b1; a.dmem_addr = 6'd3; a.dmem_wdata = 32'h00000333;
        @(negedge clk);
        chk("pl_blocked", 32'(a.pl_ready), 32'd0);
        cyc();
        a.dmem_w_en = 1'b0; a.dmem_addr = 6'd10;
        @(negedge clk);
        chk("pl_accept", 32'(a.pl_ready), 32'd1);
        chk("pl_rd_old", a.dmem_rdata, 32'h0);
        cyc();
        a.pl_valid = 1'b0;
        @(negedge clk);
        chk("pl_rd10", a.dmem_rdata, 32'h12345678);
        chk("pl_count", 32'(cnt_a), 32'd2);
        a.dmem_addr = 6'd3; #1;
        chk("pl_rd3", a.dmem_rdata, 32'h00000333);
        cyc();

        // Store to 63, then reset 30 cycles into a sweep.
        a.dmem_w_en = 1'b1; a.dmem_addr = 6'd63; a.dmem_wdata = 32'hA5A5A5A5;
        cyc();
        a.dmem_w_en = 1'b0;
        @(negedge clk);
        chk("st63", a.dmem_rdata, 32'hA5A5A5A5);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_count", 32'(cnt_a), 32'd0);
        cyc();
        for (int i = 1; i < 30; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_ready(n, nz);
        chk("reclear_len", 32'(n), 32'd64);
        a.dmem_addr = 6'd63; #1;
        chk("reclear_rd63", a.dmem_rdata, 32'h0);
        cyc();

        // Stores and preloads during CLEAR are dropped.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        a.dmem_w_en = 1'b1; a.dmem_wdata = 32'hFFFFFFFF;
        a.pl_valid = 1'b1; a.pl_addr = 6'd2; a.pl_data = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            a.dmem_addr = 6'd2;
            @(negedge clk);
            if (i == 4) chk("clr_plready", 32'(a.pl_ready), 32'd0);
            cyc();
        end
        n = 10;
        forever begin
            @(negedge clk);
            if (a.dmem_ready === 1'b1 || n > 200) break;
            n++;
            cyc();
        end
        a.dmem_w_en = 1'b0; a.pl_valid = 1'b0; a.dmem_addr = 6'd2;
        #1;
        chk("clr_len", 32'(n), 32'd64);
        chk("clr_rd2", a.dmem_rdata, 32'h0);
        chk("clr_count", 32'(cnt_a), 32'd0);
        cyc();

        // Saturating counter on the CNT_W=4 instance.
        chk("sat_ready", 32'(b.dmem_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            b.dmem_w_en = 1'b1;
            b.dmem_addr = 6'(i);
            b.dmem_wdata = 32'h1000 + 32'(i);
            cyc();
            if (i == 14) chk("sat_15", 32'(cnt_b), 32'd15);
        end
        b.dmem_w_en = 1'b0;
        @(negedge clk);
        chk("sat_hold", 32'(cnt_b), 32'd15);
        for (int i = 0; i < 20; i++) begin
            b.dmem_addr = 6'(i);
            #1;
            chk($sformatf("sat_rd%0d", i), b.dmem_rdata, 32'h1000 + 32'(i));
        end
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the dmem port that the CPU drives: `dmem_w_en`, `dmem_addr` (word address), `dmem_wdata` and `dmem_rdata`.
- Holds `DEPTH` words of storage. Reads are combinational. Writes are synchronous.
- After every reset, a clear sequencer zeroes the whole array before the block accepts traffic.
- A side preload port lets the bench or boot logic fill memory, with a valid/ready handshake.

Parameters:
- `WIDTH`, 32, data word width.
- `DEPTH`, 64, number of words.
- `ADDR_W`, 6, word address width; `DEPTH` must equal 2**`ADDR_W`.
- `CNT_W`, 16, width of the write-event counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `dmem_w_en` input 1: CPU store strobe, one word per asserted cycle.
- `dmem_addr` input `ADDR_W`: CPU word address (byte address bits [7:2]).
- `dmem_wdata` input `WIDTH`: CPU store data.
- `dmem_rdata` output `WIDTH`: read data for `dmem_addr`.
- `dmem_ready` output 1: high when the array is initialised and serving requests.
- `pl_valid` input 1: preload request.
- `pl_addr` input `ADDR_W`: preload word address.
- `pl_data` input `WIDTH`: preload data.
- `pl_ready` output 1: preload accepted this cycle (combinational).
- `wr_count` output `CNT_W`: number of committed CPU stores, saturating.

Behaviour:
- States: CLEAR and READY. The state register, a clear pointer `clr_ptr[ADDR_W-1:0]`, and `wr_count` are the only control state.
- Reset (synchronous, any cycle, including mid-CLEAR or mid-traffic):
  - Next state is CLEAR, `clr_ptr` is 0, `wr_count` is 0.
  - Array contents are not touched by reset itself; the CLEAR sweep zeroes them.
- CLEAR:
  - Each cycle writes 0 to `mem[clr_ptr]` and increments `clr_ptr`.
  - When `clr_ptr` = `DEPTH`-1 is written, the next state is READY.
  - CLEAR therefore lasts exactly `DEPTH` cycles after reset deasserts.
  - `dmem_ready`=0, `dmem_rdata`=0, `pl_ready`=0.
  - CPU stores and preloads are dropped, not queued, and `wr_count` does not change.
- READY:
  - `dmem_ready`=1; stays in READY until reset.
- Read path (READY):
  - `dmem_rdata` = `mem[dmem_addr]` combinationally, zero cycles of latency, so the CPU memory stage can register it on the same edge.
- Write path (READY):
  - If `dmem_w_en`=1, `mem[dmem_addr]` <= `dmem_wdata` on the rising edge.
  - A read of the same address in the same cycle returns the old value; the new value is visible from the next cycle.
  - No write forwarding.
- Preload (READY):
  - `pl_ready` = `pl_valid` & ~`dmem_w_en`.
  - When `pl_valid` & `pl_ready`, `mem[pl_addr]` <= `pl_data` on the edge.
  - A CPU store always wins: when both are active in a cycle, `pl_ready`=0 and the requester must hold `pl_valid`/`pl_addr`/`pl_data` until it sees `pl_ready`=1.
  - A preload and a CPU read to the same address in the same cycle: the read returns the old value.
- `wr_count`:
  - Increments by 1 on each READY-state cycle with `dmem_w_en`=1.
  - Saturates at 2**`CNT_W`-1 and holds there.
  - Preloads are not counted.
- Address rules:
  - All addresses are `ADDR_W` bits wide, so out-of-range access cannot occur.
  - The clear pointer wraps naturally after `DEPTH`-1, but the state exits CLEAR at that point, so the wrap is never used.
- Output reset values (cycle after reset asserted): `dmem_rdata`=0, `dmem_ready`=0, `pl_ready`=0, `wr_count`=0.

Test Plan:
- Reset for 2 cycles, then release. Expected:
  - `dmem_ready`=0 for exactly 64 cycles, then 1.
  - `dmem_rdata`=0 throughout.
  - Reading addresses 0, 31 and 63 after ready returns 0.
- In READY, store 0xDEADBEEF to addr 5 while reading addr 5 in the same cycle. Expected: 0xDEADBEEF is not returned that cycle; next cycle `dmem_rdata`=0xDEADBEEF and `wr_count`=1.
- `pl_valid`=1, addr 10, data 0x12345678, with `dmem_w_en`=1 to addr 3 in the same cycle. Expected:
  - `pl_ready`=0 that cycle.
  - Next cycle, with `dmem_w_en`=0 and the request held, `pl_ready`=1.
  - A read of addr 10 then gives 0x12345678, and `wr_count` counts only the CPU store.
- Store 0xA5A5A5A5 to addr 63 in READY, then assert reset for 1 cycle while 30 cycles into the clear sweep, then release. Expected:
  - CLEAR restarts from 0 and `dmem_ready` rises 64 cycles after the release.
  - A read of addr 63 returns 0.
- Assert `dmem_w_en` during CLEAR to addr 2 with 0xFFFFFFFF. Expected: after ready, addr 2 reads 0 and `wr_count`=0.
- Set `CNT_W`=4 and issue 20 consecutive stores. Expected: `wr_count` reaches 15 and holds; all 20 data writes land.
